digit_glyph_arbiter: RTL

Shares one 10-digit glyph ROM (5×5 bitmaps of digits 0–9) between up to NREQ render requesters, such as score, timer and lives-counter pixel generators that run beside the hvsync generator. Each cycle it grants one pending request in round-robin order and performs the ROM lookup. One cycle later it returns the 5-pixel row slice, tagged with the requester ID. This lets several on-screen number fields use a single ROM instance.

---
 rtl/glyph_pkg.sv | 40 ++++
 rtl/digit_glyph_rom.sv | 29 ++
 rtl/digit_glyph_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/glyph_pkg.sv
// glyph_pkg
// Shared constants and the 5x5 digit bitmap table used by the glyph ROM and
// the arbiter that shares it.
//   GLYPH_W    : pixels per glyph row
//   GLYPH_ROWS : rows per glyph
//   DIGIT_W    : width of a digit code
//   YOFS_W     : width of a row offset
//   NUM_DIGITS : number of valid digit codes (0..9)
package glyph_pkg;

    localparam int GLYPH_W    = 5;
    localparam int GLYPH_ROWS = 5;
    localparam int DIGIT_W    = 4;
    localparam int YOFS_W     = 3;
    localparam int NUM_DIGITS = 10;

    typedef logic [GLYPH_W-1:0]            glyph_row_t;
    typedef logic [GLYPH_W*GLYPH_ROWS-1:0] glyph_bitmap_t;

    // Whole bitmap for one digit; row 0 sits in the top five bits and bit 4
    // of each row is the leftmost pixel. Codes 10..15 map to a blank glyph.
    function automatic glyph_bitmap_t glyph_bitmap(input logic [DIGIT_W-1:0] digit);
        glyph_bitmap_t bm;
        case (digit)
            4'd0:    bm = {5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b11111};
            4'd1:    bm = {5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b11111};
            4'd2:    bm = {5'b11111, 5'b00001, 5'b11111, 5'b10000, 5'b11111};
            4'd3:    bm = {5'b11111, 5'b00001, 5'b11111, 5'b00001, 5'b11111};
            4'd4:    bm = {5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001};
            4'd5:    bm = {5'b11111, 5'b10000, 5'b11111, 5'b00001, 5'b11111};
            4'd6:    bm = {5'b11111, 5'b10000, 5'b11111, 5'b10001, 5'b11111};
            4'd7:    bm = {5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
            4'd8:    bm = {5'b11111, 5'b10001, 5'b11111, 5'b10001, 5'b11111};
            4'd9:    bm = {5'b11111, 5'b10001, 5'b11111, 5'b00001, 5'b11111};
            default: bm = '0;
        endcase
        return bm;
    endfunction

endpackage

// File: rtl/digit_glyph_rom.sv
// digit_glyph_rom
// Combinational glyph lookup: selects one 5-pixel row of a digit bitmap.
//   digit    : digit code; codes above 9 give a blank row
//   yofs     : row offset within the glyph; offsets above 4 give a blank row
//   row_bits : selected row, bit 4 = leftmost pixel
module digit_glyph_rom
    import glyph_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic [YOFS_W-1:0]  yofs,
    output glyph_row_t         row_bits
);

    glyph_bitmap_t bitmap;

    always_comb begin
        bitmap   = glyph_bitmap(digit);
        row_bits = '0;
        case (yofs)
            3'd0:    row_bits = bitmap[24:20];
            3'd1:    row_bits = bitmap[19:15];
            3'd2:    row_bits = bitmap[14:10];
            3'd3:    row_bits = bitmap[9:5];
            3'd4:    row_bits = bitmap[4:0];
            default: row_bits = '0;
        endcase
    end

endmodule

// File: rtl/digit_glyph_arbiter.sv
// digit_glyph_arbiter
// Round-robin arbiter sharing one digit glyph ROM between NREQ requesters.
// The granted requester's digit/row offset is looked up in the grant cycle
// and the row is returned, tagged with the requester index, one cycle later.
//   clk       : system clock
//   reset     : asynchronous, active-low reset
//   req       : per-requester request, held until granted
//   req_digit : packed digit codes, requester i at [4i+3:4i]
//   req_yofs  : packed row offsets, requester i at [3i+2:3i]
//   gnt       : one-hot grant, combinational, zero while in reset
//   rsp_valid : registered, one cycle per grant
//   rsp_id    : registered index of the answered requester
//   rsp_bits  : registered glyph row, bit 4 = leftmost pixel
module digit_glyph_arbiter
    import glyph_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DIGIT_W-1:0]   req_digit,
    input  logic [NREQ*YOFS_W-1:0]    req_yofs,
    output logic [NREQ-1:0]           gnt,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [GLYPH_W-1:0]        rsp_bits
);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    glyph_row_t         rsp_bits_q, rsp_bits_d;

    logic [DIGIT_W-1:0] digit_arr [NREQ];
    logic [YOFS_W-1:0]  yofs_arr  [NREQ];

    logic               gnt_any;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W:0]      cand;
    logic [NREQ-1:0]    gnt_raw;
    logic [DIGIT_W-1:0] sel_digit;
    logic [YOFS_W-1:0]  sel_yofs;
    glyph_row_t         rom_row;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign digit_arr[gi] = req_digit[gi*DIGIT_W +: DIGIT_W];
            assign yofs_arr[gi]  = req_yofs[gi*YOFS_W +: YOFS_W];
        end
    endgenerate

    // Find-first starting at ptr. The candidate index carries one extra bit
    // so the modulo-NREQ wrap works for non-power-of-two NREQ. Nothing is
    // granted while reset is held low.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        gnt_raw = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end
            if (!gnt_any && reset && req[cand[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
        if (gnt_any) begin
            gnt_raw[gnt_idx] = 1'b1;
        end
    end

    assign gnt = gnt_raw;

    // Single shared ROM fed by the granted requester's operands.
    assign sel_digit = digit_arr[gnt_idx];
    assign sel_yofs  = yofs_arr[gnt_idx];

    digit_glyph_rom u_rom (
        .digit    (sel_digit),
        .yofs     (sel_yofs),
        .row_bits (rom_row)
    );

    // Pointer moves past the winner; id/bits hold when nothing is granted.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = gnt_any;
        rsp_id_d    = rsp_id_q;
        rsp_bits_d  = rsp_bits_q;
        if (gnt_any) begin
            ptr_d      = (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            rsp_id_d   = gnt_idx;
            rsp_bits_d = rom_row;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_bits_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_bits_q  <= rsp_bits_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_bits  = rsp_bits_q;

endmodule
